id_stage_pipelined: RTL and testbench
=====================================

// Module: id_stage_pipelined
// PURPOSE
//  Parametrised MIPS decode stage: field decode, 2R/1W register file with WB->ID bypass,
//  load-use hazard detect, early beq/bne/jr resolve, and registered ID/EX outputs.
//  Sits between IF and EX; drives hazard_stall back to IF.
// PARAMETERS
//  DATA_W     32  register/data width (>=16)
//  REG_AW     5   register address width; 2**REG_AW registers, r0 hardwired 0
//  BYPASS_EN  1   1: same-cycle WB write visible on ID reads; 0: read old value
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, synchronous, active-high
//  halted         in   1       1: block regfile writes, hold ID/EX register
//  in_valid       in   1       inst/pc_plus4 valid from IF
//  inst           in   32      instruction word
//  pc_plus4       in   DATA_W  PC of inst + 4
//  extender       in   1       1: sign-extend imm16, 0: zero-extend
//  stall_in       in   1       downstream stall; hold ID/EX register
//  flush          in   1       kill ID/EX contents (bubble)
//  wb_we          in   1       WB register write enable
//  wb_rd          in   REG_AW  WB destination
//  wb_data        in   DATA_W  WB data
//  ex_mem_read    in   1       instruction in EX is a load
//  ex_rd          in   REG_AW  destination of instruction in EX
//  hazard_stall   out  1       comb: load-use hazard, IF must hold
//  branch_taken   out  1       comb: beq/bne taken, IF redirects to branch_target
//  branch_target  out  DATA_W  comb: pc_plus4 + (sext(imm16) << 2)
//  jr_select      out  1       comb: jr decoded (opcode 0, func 001000)
//  jr_target      out  DATA_W  comb: bypassed rs data
//  out_valid      out  1       ID/EX valid
//  out_opcode/out_func  out 6  registered fields
//  out_rs/out_rt/out_rd out REG_AW; out_shamt out 5
//  out_imm        out  DATA_W  extended immediate
//  out_rs_data/out_rt_data out DATA_W  bypassed operand values
//  stall_cnt      out  16      saturating count of hazard_stall cycles
// BEHAVIOUR
//  - Fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] func[5:0] imm[15:0];
//    reg fields are the low REG_AW bits (zero-padded if REG_AW>5).
//  - Regfile: write on posedge if wb_we && !halted && wb_rd!=0; r0 reads 0. rst zeroes all.
//  - Bypass (BYPASS_EN=1): read addr==wb_rd!=0 && wb_we && !halted -> wb_data.
//  - uses_rt = R-type(op 0) | beq(000100) | bne(000101) | sw(101011).
//  - hazard_stall = in_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs | (uses_rt & ex_rd==rt)).
//  - branch_taken = in_valid & !hazard_stall & !stall_in & !flush &
//    ((beq & rs==rt data) | (bne & rs!=rt data)); compare uses bypassed data.
//  - jr_select qualified by in_valid only; target valid when !hazard_stall.
//  - ID/EX register, latency 1, priority per posedge:
//    rst -> out_valid=0, all out_* =0, stall_cnt=0;
//    flush -> out_valid=0, fields zeroed (flush beats stall_in/halted);
//    stall_in | halted -> hold all outputs;
//    hazard_stall -> bubble: out_valid=0, fields zeroed;
//    else -> load decoded fields/data, out_valid=in_valid.
//  - stall_cnt +1 each cycle hazard_stall=1 and !halted; saturates at 16'hFFFF; rst clears.
//  - Reset mid-operation discards the ID/EX contents; the first instruction after rst
//    deasserts appears on outputs one cycle later.
// TESTING
//  - WB r5=0x1234 then ID reads rs=5 in same cycle: BYPASS_EN=1 -> rs_data 0x1234;
//    BYPASS_EN=0 -> old value.
//  - ex_mem_read=1 ex_rd=8, inst add $3,$8,$9 -> hazard_stall=1, out_valid=0 next cycle,
//    stall_cnt=1; ex_rd=0 -> no stall.
//  - beq $1,$2,-1 with r1=r2=7, pc_plus4=0x100 -> branch_taken=1, target 0xFC;
//    bne same -> 0.
//  - stall_in=1 for 3 cycles -> outputs held; flush=1 with stall_in=1 -> out_valid=0.
//  - wb_rd=0 wb_data=0xFFFF -> r0 still reads 0; halted=1 blocks a write to r4.
//  - Force 70000 hazard cycles -> stall_cnt=16'hFFFF; rst=1 -> all outputs 0 next edge.

Source files
------------

// File: rtl/id_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipelined
// Brief    : MIPS decode stage with WB->ID bypassing register file, load-use
//            hazard detect, early beq/bne/jr resolve and an ID/EX register.
// Revision : 1.0
// ============================================================================
module id_stage_pipelined #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    input  logic              in_valid,
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              extender,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              hazard_stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              jr_select,
    output logic [DATA_W-1:0] jr_target,
    output logic              out_valid,
    output logic [5:0]        out_opcode,
    output logic [5:0]        out_func,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [4:0]        out_shamt,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [15:0]       stall_cnt
);

    localparam int         NREG       = 2 ** REG_AW;
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_func_jr  = 6'h08;
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [5:0]        w_op;
    logic [5:0]        w_func;
    logic [4:0]        w_shamt;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_imm_zext;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rs_raw;
    logic [DATA_W-1:0] w_rt_raw;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_wr_en;
    logic              w_uses_rt;
    logic              w_hold;

    assign w_op    = inst[31:26];
    assign w_func  = inst[5:0];
    assign w_shamt = inst[10:6];

    generate
        if (REG_AW <= 5) begin : g_reg_narrow
            assign w_rs = inst[21 +: REG_AW];
            assign w_rt = inst[16 +: REG_AW];
            assign w_rd = inst[11 +: REG_AW];
        end else begin : g_reg_wide
            assign w_rs = {{(REG_AW-5){1'b0}}, inst[25:21]};
            assign w_rt = {{(REG_AW-5){1'b0}}, inst[20:16]};
            assign w_rd = {{(REG_AW-5){1'b0}}, inst[15:11]};
        end
    endgenerate

    assign w_imm_sext = DATA_W'($signed(inst[15:0]));
    assign w_imm_zext = DATA_W'(inst[15:0]);
    assign w_imm      = extender ? w_imm_sext : w_imm_zext;

    // ------------------------------------------------------------------
    // Register file; r0 is never written and always reads as zero
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [NREG];

    assign w_wr_en = wb_we && !halted && (wb_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    assign w_rs_raw = (w_rs == '0) ? '0 : regs_q[w_rs];
    assign w_rt_raw = (w_rt == '0) ? '0 : regs_q[w_rt];

    generate
        if (BYPASS_EN != 0) begin : g_bypass
            assign w_rs_data = (w_wr_en && (wb_rd == w_rs)) ? wb_data : w_rs_raw;
            assign w_rt_data = (w_wr_en && (wb_rd == w_rt)) ? wb_data : w_rt_raw;
        end else begin : g_no_bypass
            assign w_rs_data = w_rs_raw;
            assign w_rt_data = w_rt_raw;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard detect and early control-flow resolve
    // ------------------------------------------------------------------
    assign w_uses_rt = (w_op == c_op_rtype) || (w_op == c_op_beq) ||
                       (w_op == c_op_bne)   || (w_op == c_op_sw);

    assign hazard_stall = in_valid && ex_mem_read && (ex_rd != '0) &&
                          ((ex_rd == w_rs) || (w_uses_rt && (ex_rd == w_rt)));

    assign branch_taken = in_valid && !hazard_stall && !stall_in && !flush &&
                          (((w_op == c_op_beq) && (w_rs_data == w_rt_data)) ||
                           ((w_op == c_op_bne) && (w_rs_data != w_rt_data)));

    assign branch_target = pc_plus4 + (w_imm_sext << 2);
    assign jr_select     = in_valid && (w_op == c_op_rtype) && (w_func == c_func_jr);
    assign jr_target     = w_rs_data;

    // ------------------------------------------------------------------
    // ID/EX register and stall counter
    // ------------------------------------------------------------------
    logic              valid_q,  valid_d;
    logic [5:0]        op_q,     op_d;
    logic [5:0]        func_q,   func_d;
    logic [REG_AW-1:0] rs_q,     rs_d;
    logic [REG_AW-1:0] rt_q,     rt_d;
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [4:0]        shamt_q,  shamt_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [DATA_W-1:0] rsd_q,    rsd_d;
    logic [DATA_W-1:0] rtd_q,    rtd_d;
    logic [15:0]       cnt_q,    cnt_d;

    assign w_hold = stall_in || halted;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        func_d  = func_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        shamt_d = shamt_q;
        imm_d   = imm_q;
        rsd_d   = rsd_q;
        rtd_d   = rtd_q;
        // flush outranks hold; a hazard only bubbles when the stage advances
        if (flush || (!w_hold && hazard_stall)) begin
            valid_d = 1'b0;
            op_d    = '0;
            func_d  = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            shamt_d = '0;
            imm_d   = '0;
            rsd_d   = '0;
            rtd_d   = '0;
        end else if (!w_hold) begin
            valid_d = in_valid;
            op_d    = w_op;
            func_d  = w_func;
            rs_d    = w_rs;
            rt_d    = w_rt;
            rd_d    = w_rd;
            shamt_d = w_shamt;
            imm_d   = w_imm;
            rsd_d   = w_rs_data;
            rtd_d   = w_rt_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hazard_stall && !halted && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            func_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            imm_q   <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            func_q  <= func_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            imm_q   <= imm_d;
            rsd_q   <= rsd_d;
            rtd_q   <= rtd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_opcode  = op_q;
    assign out_func    = func_q;
    assign out_rs      = rs_q;
    assign out_rt      = rt_q;
    assign out_rd      = rd_q;
    assign out_shamt   = shamt_q;
    assign out_imm     = imm_q;
    assign out_rs_data = rsd_q;
    assign out_rt_data = rtd_q;
    assign stall_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_pipelined
// Brief    : Directed plus randomized bench for id_stage_pipelined against a
//            behavioural decode/regfile model.
// Revision : 1.0
// ============================================================================
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst, halted, in_valid, extender, stall_in, flush;
    logic        wb_we, ex_mem_read;
    logic [31:0] inst, pc_plus4, wb_data;
    logic [4:0]  wb_rd, ex_rd;
    logic        hazard_stall, branch_taken, jr_select, out_valid;
    logic [31:0] branch_target, jr_target, out_imm, out_rs_data, out_rt_data;
    logic [5:0]  out_opcode, out_func;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    id_stage_pipelined #(.DATA_W(32), .REG_AW(5), .BYPASS_EN(1)) dut (
        .clk(clk), .rst(rst), .halted(halted), .in_valid(in_valid), .inst(inst),
        .pc_plus4(pc_plus4), .extender(extender), .stall_in(stall_in), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .jr_select(jr_select), .jr_target(jr_target),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_func(out_func),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers, expected ID/EX contents, counter
    logic [31:0] regs_m [32];
    logic        m_valid;
    logic [5:0]  m_op, m_func;
    logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
    logic [31:0] m_imm, m_rsd, m_rtd;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] read_m(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && !halted && wb_rd == a) return wb_data;
        return regs_m[a];
    endfunction

    task automatic clear_m();
        m_valid = 1'b0; m_op = '0; m_func = '0; m_rs = '0; m_rt = '0;
        m_rd = '0; m_shamt = '0; m_imm = '0; m_rsd = '0; m_rtd = '0;
    endtask

    // One cycle: check combinational outputs, advance model, check registered outputs
    task automatic step();
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [31:0] rsd, rtd, sx, zx;
        logic        uses_rt, hz, bt, frozen;
        #1;
        op  = inst[31:26];
        rs  = inst[25:21];
        rt  = inst[20:16];
        rsd = read_m(rs);
        rtd = read_m(rt);
        sx  = {{16{inst[15]}}, inst[15:0]};
        zx  = {16'd0, inst[15:0]};
        uses_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
        hz = in_valid && ex_mem_read && ex_rd != 0 && (ex_rd == rs || (uses_rt && ex_rd == rt));
        bt = in_valid && !hz && !stall_in && !flush &&
             ((op == 6'd4 && rsd == rtd) || (op == 6'd5 && rsd != rtd));
        chk("hazard_stall", 32'(hazard_stall), 32'(hz));
        chk("branch_taken", 32'(branch_taken), 32'(bt));
        chk("branch_target", branch_target, pc_plus4 + sx * 4);
        chk("jr_select", 32'(jr_select), 32'(in_valid && op == 6'd0 && inst[5:0] == 6'd8));
        chk("jr_target", jr_target, rsd);
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_m[i] = '0;
            clear_m();
            m_cnt = 0;
        end else begin
            frozen = stall_in || halted;
            if (flush || (!frozen && hz)) clear_m();
            else if (!frozen) begin
                m_valid = in_valid; m_op = op; m_func = inst[5:0]; m_rs = rs; m_rt = rt;
                m_rd = inst[15:11]; m_shamt = inst[10:6]; m_imm = extender ? sx : zx;
                m_rsd = rsd; m_rtd = rtd;
            end
            if (hz && !halted && m_cnt < 65535) m_cnt++;
            if (wb_we && !halted && wb_rd != 0) regs_m[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_opcode", 32'(out_opcode), 32'(m_op));
        chk("out_func", 32'(out_func), 32'(m_func));
        chk("out_rs", 32'(out_rs), 32'(m_rs));
        chk("out_rt", 32'(out_rt), 32'(m_rt));
        chk("out_rd", 32'(out_rd), 32'(m_rd));
        chk("out_shamt", 32'(out_shamt), 32'(m_shamt));
        chk("out_imm", out_imm, m_imm);
        chk("out_rs_data", out_rs_data, m_rsd);
        chk("out_rt_data", out_rt_data, m_rtd);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic quiet();
        rst = 0; halted = 0; in_valid = 0; inst = 0; pc_plus4 = 0; extender = 1;
        stall_in = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        ex_mem_read = 0; ex_rd = 0;
    endtask

    task automatic randomize_inputs();
        logic [5:0] op;
        case ($urandom_range(0, 7))
            0, 1, 2: op = 6'd0;
            3:       op = 6'd4;
            4:       op = 6'd5;
            5:       op = 6'd43;
            6:       op = 6'd35;
            default: op = 6'($urandom_range(0, 63));
        endcase
        inst = $urandom;
        inst[31:26] = op;
        inst[25:21] = 5'($urandom_range(0, 7));
        inst[20:16] = 5'($urandom_range(0, 7));
        if (op == 6'd0 && $urandom_range(0, 3) == 0) inst[5:0] = 6'd8;
        pc_plus4    = $urandom & 32'hFFFF_FFFC;
        in_valid    = ($urandom_range(0, 7) != 0);
        extender    = 1'($urandom);
        stall_in    = ($urandom_range(0, 7) == 0);
        flush       = ($urandom_range(0, 9) == 0);
        halted      = ($urandom_range(0, 9) == 0);
        wb_we       = 1'($urandom);
        wb_rd       = 5'($urandom_range(0, 7));
        wb_data     = $urandom;
        ex_mem_read = ($urandom_range(0, 2) == 0);
        ex_rd       = 5'($urandom_range(0, 7));
    endtask

    initial begin
        int c0;
        quiet();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        clear_m();
        m_cnt = 0;
        step();

        // Same-cycle WB write of r5 seen by jr $5
        quiet();
        in_valid = 1; inst = {6'd0, 5'd5, 5'd0, 5'd0, 5'd0, 6'h08};
        wb_we = 1; wb_rd = 5'd5; wb_data = 32'h1234;
        step();
        chk("bypass_rs_data", out_rs_data, 32'h1234);
        chk("bypass_jr_target", jr_target, 32'h1234);

        // Load-use hazard on add $3,$8,$9
        quiet();
        in_valid = 1; inst = {6'd0, 5'd8, 5'd9, 5'd3, 5'd0, 6'h20};
        ex_mem_read = 1; ex_rd = 5'd8;
        step();
        chk("hz_stall", 32'(hazard_stall), 32'd1);
        chk("hz_bubble", 32'(out_valid), 32'd0);
        chk("hz_cnt", 32'(stall_cnt), 32'd1);
        ex_rd = 5'd0;
        step();
        chk("hz_exrd0", 32'(hazard_stall), 32'd0);
        chk("hz_exrd0_valid", 32'(out_valid), 32'd1);

        // beq/bne $1,$2,-1 with r1 == r2 == 7
        quiet();
        wb_we = 1; wb_rd = 5'd1; wb_data = 32'd7;
        step();
        wb_rd = 5'd2;
        step();
        wb_we = 0; in_valid = 1; pc_plus4 = 32'h100;
        inst = {6'd4, 5'd1, 5'd2, 16'hFFFF};
        step();
        chk("beq_taken", 32'(branch_taken), 32'd1);
        chk("beq_target", branch_target, 32'hFC);
        inst = {6'd5, 5'd1, 5'd2, 16'hFFFF};
        step();
        chk("bne_taken", 32'(branch_taken), 32'd0);

        // Hold for three stalled cycles, then flush during stall
        inst = {6'd0, 5'd1, 5'd2, 5'd7, 5'd3, 6'h22};
        step();
        stall_in = 1;
        for (int k = 0; k < 3; k++) begin
            inst = $urandom;
            step();
            chk("stall_hold_rd", 32'(out_rd), 32'd7);
        end
        flush = 1;
        step();
        chk("flush_over_stall", 32'(out_valid), 32'd0);

        // r0 stays zero; halted blocks a write to r4
        quiet();
        in_valid = 1; inst = {6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h08};
        wb_we = 1; wb_rd = 5'd0; wb_data = 32'hFFFF;
        step();
        chk("r0_zero", jr_target, 32'd0);
        in_valid = 0; halted = 1; wb_rd = 5'd4; wb_data = 32'hABCD;
        step();
        quiet();
        in_valid = 1; inst = {6'd0, 5'd4, 5'd0, 5'd0, 5'd0, 6'h08};
        step();
        chk("halted_no_write", out_rs_data, 32'd0);

        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            step();
        end

        // Long load-use stall to drive the counter into saturation
        quiet();
        in_valid = 1; inst = {6'd0, 5'd8, 5'd9, 5'd3, 5'd0, 6'h20};
        ex_mem_read = 1; ex_rd = 5'd8;
        step();
        c0 = m_cnt;
        repeat (70000) @(posedge clk);
        #1;
        m_cnt = (c0 + 70000 > 65535) ? 65535 : c0 + 70000;
        chk("cnt_saturate", 32'(stall_cnt), 32'hFFFF);
        chk("cnt_saturate_model", 32'(stall_cnt), 32'(m_cnt));
        chk("sat_bubble", 32'(out_valid), 32'd0);

        // Reset mid-run with a valid instruction pending
        ex_mem_read = 0;
        step();
        rst = 1;
        step();
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        rst = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
